// File: rtl/encoder_emulator.sv
// rtl/encoder_emulator.sv - synthetic quadrature/index/hall encoder source; optional ENCODER_EMU_FAULT_EN adds fault_in overrides
module encoder_emulator #(
    parameter int LINES      = 1200,
    parameter int POLE_PAIRS = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           en_in,
    input  logic                           dir_in,
    input  logic [DIV_WIDTH-1:0]           period_in,
`ifdef ENCODER_EMU_FAULT_EN
    input  logic [1:0]                     fault_in,
`endif
    output logic                           enc_a,
    output logic                           enc_b,
    output logic                           enc_z,
    output logic                           enc_u,
    output logic                           enc_v,
    output logic                           enc_w,
    output logic [$clog2(4*LINES)-1:0]     pos_out,
    output logic                           step_out
);

    localparam int CNT        = 4 * LINES;
    localparam int POS_W      = $clog2(CNT);
    localparam int SECT_STEPS = CNT / (6 * POLE_PAIRS);
    localparam int HW         = (SECT_STEPS > 1) ? $clog2(SECT_STEPS) : 1;

    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(CNT - 1);
    localparam logic [HW-1:0]    SECT_LAST = HW'(SECT_STEPS - 1);

    generate
        if (CNT % (6 * POLE_PAIRS) != 0) begin : g_bad_sect
            $error("encoder_emulator: 4*LINES must be a multiple of 6*POLE_PAIRS");
        end
    endgenerate

    function automatic logic [2:0] hall_code(input logic [2:0] s);
        case (s)
            3'd0:    hall_code = 3'b101;
            3'd1:    hall_code = 3'b100;
            3'd2:    hall_code = 3'b110;
            3'd3:    hall_code = 3'b010;
            3'd4:    hall_code = 3'b011;
            default: hall_code = 3'b001;
        endcase
    endfunction

    logic [DIV_WIDTH-1:0] div_cnt;
    logic [POS_W-1:0]     pos, pos_nxt;
    logic [HW-1:0]        hcnt, hcnt_nxt;
    logic [2:0]           sector, sector_nxt;
    logic                 running, step;
    logic                 a_nxt, b_nxt;
    logic [2:0]           uvw_nxt;

    assign running = en_in && (period_in != '0);
    // >= rather than == so a shrinking period never lets div_cnt overrun
    assign step    = running && (div_cnt >= period_in - DIV_WIDTH'(1));

    always_comb begin
        pos_nxt    = pos;
        hcnt_nxt   = hcnt;
        sector_nxt = sector;
        if (step) begin
            if (!dir_in) begin
                pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
                if (hcnt == SECT_LAST) begin
                    hcnt_nxt   = '0;
                    sector_nxt = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
                end else begin
                    hcnt_nxt = hcnt + HW'(1);
                end
            end else begin
                pos_nxt = (pos == '0) ? POS_LAST : pos - POS_W'(1);
                if (hcnt == '0) begin
                    hcnt_nxt   = SECT_LAST;
                    sector_nxt = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
                end else begin
                    hcnt_nxt = hcnt - HW'(1);
                end
            end
        end
    end

    // Outputs are registered from next-state so every output moves on the step edge
    always_comb begin
        a_nxt   = pos_nxt[1] ^ pos_nxt[0];
        b_nxt   = pos_nxt[1];
        uvw_nxt = hall_code(sector_nxt);
`ifdef ENCODER_EMU_FAULT_EN
        case (fault_in)
            2'b01:   uvw_nxt = 3'b000;
            2'b10:   uvw_nxt = 3'b111;
            2'b11: begin
                a_nxt = enc_a;
                b_nxt = enc_b;
            end
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt  <= '0;
            pos      <= '0;
            hcnt     <= '0;
            sector   <= 3'd0;
            enc_a    <= 1'b0;
            enc_b    <= 1'b0;
            enc_z    <= 1'b0;
            enc_u    <= 1'b1;
            enc_v    <= 1'b0;
            enc_w    <= 1'b1;
            step_out <= 1'b0;
        end else begin
            div_cnt  <= (!running || step) ? '0 : div_cnt + DIV_WIDTH'(1);
            pos      <= pos_nxt;
            hcnt     <= hcnt_nxt;
            sector   <= sector_nxt;
            enc_a    <= a_nxt;
            enc_b    <= b_nxt;
            enc_z    <= en_in && (pos_nxt == '0);
            {enc_u, enc_v, enc_w} <= uvw_nxt;
            step_out <= step;
        end
    end

    assign pos_out = pos;

endmodule

// File: tb/tb_encoder_emulator.sv
// tb/tb_encoder_emulator.sv - directed bench for encoder_emulator
module tb_encoder_emulator;

    logic        clk_in = 1'b0;
    logic        rst_in, en_in, dir_in;
    logic [15:0] period_in;
`ifdef ENCODER_EMU_FAULT_EN
    logic [1:0]  fault_in;
`endif
    logic        enc_a, enc_b, enc_z, enc_u, enc_v, enc_w, step_out;
    logic [12:0] pos_out;
    logic [2:0]  uvw, prev_uvw;

    int tests = 0;
    int fails = 0;
    int changes, illegal, bad;

    assign uvw = {enc_u, enc_v, enc_w};

    encoder_emulator dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (en_in),
        .dir_in    (dir_in),
        .period_in (period_in),
`ifdef ENCODER_EMU_FAULT_EN
        .fault_in  (fault_in),
`endif
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .enc_z     (enc_z),
        .enc_u     (enc_u),
        .enc_v     (enc_v),
        .enc_w     (enc_w),
        .pos_out   (pos_out),
        .step_out  (step_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [2:0] hall_exp(input int s);
        case (s)
            0:       hall_exp = 3'b101;
            1:       hall_exp = 3'b100;
            2:       hall_exp = 3'b110;
            3:       hall_exp = 3'b010;
            4:       hall_exp = 3'b011;
            default: hall_exp = 3'b001;
        endcase
    endfunction

    initial begin
        rst_in = 1'b1; en_in = 1'b0; dir_in = 1'b0; period_in = 16'd0;
`ifdef ENCODER_EMU_FAULT_EN
        fault_in = 2'b00;
`endif
        // reset hold, then idle with en_in low
        repeat (3) tick;
        rst_in = 1'b0;
        repeat (5) tick;
        check("idle_ab",   {enc_a, enc_b}, 2'b00);
        check("idle_z",    enc_z, 1'b0);
        check("idle_uvw",  uvw, 3'b101);
        check("idle_pos",  pos_out, 0);
        check("idle_step", step_out, 1'b0);

        // forward, period 3, 20 steps
        en_in = 1'b1; period_in = 16'd3;
        for (int k = 1; k <= 20; k++) begin
            logic [1:0] kk;
            kk = 2'(k);
            tick;
            check("p3_gap1_step", step_out, 1'b0);
            check("p3_z", enc_z, (k == 1));
            tick;
            check("p3_gap2_step", step_out, 1'b0);
            tick;
            check("p3_step", step_out, 1'b1);
            check("p3_pos", pos_out, k);
            check("p3_ab", {enc_a, enc_b}, {kk[1] ^ kk[0], kk[1]});
            check("p3_uvw", uvw, 3'b101);
            check("p3_z_after", enc_z, 1'b0);
        end

        // full forward revolution at period 1
        rst_in = 1'b1;
        tick;
        rst_in = 1'b0; en_in = 1'b1; dir_in = 1'b0; period_in = 16'd1;
        changes = 0; illegal = 0; bad = 0; prev_uvw = 3'b101;
        for (int i = 1; i <= 4799; i++) begin
            tick;
            if (uvw !== hall_exp((i / 200) % 6)) bad++;
            if (uvw !== prev_uvw) changes++;
            if (uvw == 3'b000 || uvw == 3'b111) illegal++;
            if (enc_z !== 1'b0) bad++;
            if (pos_out !== 13'(i)) bad++;
            prev_uvw = uvw;
        end
        check("rev_pos_last", pos_out, 4799);
        check("rev_bad", bad, 0);
        tick;
        if (uvw !== prev_uvw) changes++;
        check("rev_wrap_pos", pos_out, 0);
        check("rev_wrap_z", enc_z, 1'b1);
        check("rev_wrap_uvw", uvw, 3'b101);
        check("rev_changes", changes, 24);
        check("rev_illegal", illegal, 0);

        // reverse from pos 0
        dir_in = 1'b1;
        tick;
        check("bwd_pos1", pos_out, 4799);
        check("bwd_ab1", {enc_a, enc_b}, 2'b01);
        check("bwd_uvw1", uvw, 3'b001);
        check("bwd_z1", enc_z, 1'b0);
        tick;
        check("bwd_pos2", pos_out, 4798);
        check("bwd_ab2", {enc_a, enc_b}, 2'b11);
        en_in = 1'b0;
        tick;
        check("halt_pos", pos_out, 4798);
        check("halt_step", step_out, 1'b0);
        tick;
        check("halt_pos2", pos_out, 4798);

        // period shrink mid-count, direction toggles, mid-run reset
        rst_in = 1'b1;
        tick;
        rst_in = 1'b0; dir_in = 1'b0; en_in = 1'b1; period_in = 16'd100;
        repeat (50) tick;
        check("shr_pre_pos", pos_out, 0);
        check("shr_pre_step", step_out, 1'b0);
        period_in = 16'd2;
        tick;
        check("shr_step", step_out, 1'b1);
        check("shr_pos1", pos_out, 1);
        tick;
        check("shr_gap", step_out, 1'b0);
        tick;
        check("shr_pos2", pos_out, 2);
        dir_in = 1'b1;
        tick;
        check("dir_gap", pos_out, 2);
        tick;
        check("dir_rev_pos", pos_out, 1);
        check("dir_rev_ab", {enc_a, enc_b}, 2'b10);
        dir_in = 1'b0;
        tick;
        tick;
        check("dir_fwd_pos", pos_out, 2);
        tick;
        rst_in = 1'b1;
        tick;
        check("mrst_pos",  pos_out, 0);
        check("mrst_step", step_out, 1'b0);
        check("mrst_ab",   {enc_a, enc_b}, 2'b00);
        check("mrst_z",    enc_z, 1'b0);
        check("mrst_uvw",  uvw, 3'b101);
        rst_in = 1'b0;

`ifdef ENCODER_EMU_FAULT_EN
        rst_in = 1'b1;
        tick;
        rst_in = 1'b0; en_in = 1'b1; dir_in = 1'b0; period_in = 16'd1;
        tick;
        tick;
        fault_in = 2'b01;
        tick;
        check("flt_uvw0", uvw, 3'b000);
        check("flt_pos3", pos_out, 3);
        fault_in = 2'b00;
        tick;
        check("flt_uvw_ok", uvw, 3'b101);
        check("flt_pos4", pos_out, 4);
        fault_in = 2'b11;
        tick;
        tick;
        tick;
        check("flt_ab_frozen", {enc_a, enc_b}, 2'b00);
        check("flt_pos7", pos_out, 7);
        fault_in = 2'b00;
        tick;
        tick;
        check("flt_ab_restored", {enc_a, enc_b}, 2'b10);
        check("flt_pos9", pos_out, 9);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
